// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes and op-class decode.
// Define MDU_MADD_EN to enable the MADD/MADDU accumulate ops (7/8).
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;

  typedef struct packed {
    logic is_mul;
    logic is_div;
    logic is_mt;
  } mdu_class_t;

  // Unrecognised codes (and MADD/MADDU when disabled) fall out as all-zero, i.e. NOP.
  function automatic mdu_class_t mdu_decode(input logic [3:0] op);
    mdu_class_t c;
    c = '{is_mul: 1'b0, is_div: 1'b0, is_mt: 1'b0};
    case (op)
      MDU_MULT, MDU_MULTU: c.is_mul = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: c.is_mul = 1'b1;
`endif
      MDU_DIV, MDU_DIVU:   c.is_div = 1'b1;
      MDU_MTHI, MDU_MTLO:  c.is_mt  = 1'b1;
      default:             c = '{is_mul: 1'b0, is_div: 1'b0, is_mt: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mdu_latency_ctr.sv
// Loadable down-counter that models multiplier/divider latency.
// busy is high while the count is non-zero; done marks the final busy cycle.
module mdu_latency_ctr
  import mdu_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done,
  output logic          busy
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= {CW{1'b0}};
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != {CW{1'b0}}) begin
      r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign busy = (r_count != {CW{1'b0}});
  assign done = (r_count == {{(CW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; results commit after MUL_LAT/DIV_LAT busy cycles.
// Optional MDU_MADD_EN adds MADD/MADDU (accumulate product into {hi,lo}).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  mdu_class_t        w_cls;
  logic              w_issue;
  logic              w_load;
  logic              w_done;
  logic              w_busy;
  logic [CW-1:0]     w_load_val;
  logic [WIDTH-1:0]  r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic [WIDTH-1:0]  w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
  logic signed [WIDTH-1:0] w_a_s, w_b_s, w_q_s, w_r_s;
  logic [WIDTH-1:0]  w_q_u, w_r_u;

  assign w_cls      = mdu_decode(op);
  assign w_issue    = start & ~w_busy;
  assign w_load     = w_issue & (w_cls.is_mul | w_cls.is_div);
  assign w_load_val = w_cls.is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);

  mdu_latency_ctr #(.CW(CW)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .done     (w_done),
    .busy     (w_busy)
  );

  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign w_prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign w_prod_u = {ZERO, a} * {ZERO, b};

  assign w_a_s = a;
  assign w_b_s = b;
  assign w_q_s = w_a_s / w_b_s;
  assign w_r_s = w_a_s % w_b_s;
  assign w_q_u = a / b;
  assign w_r_u = a % b;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] w_acc_s, w_acc_u;
  assign w_acc_s = {r_hi, r_lo} + w_prod_s;
  assign w_acc_u = {r_hi, r_lo} + w_prod_u;
`endif

  // Result selection; divide-by-zero and signed overflow get fixed architectural values.
  always_comb begin
    w_res_hi = ZERO;
    w_res_lo = ZERO;
    case (op)
      MDU_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      MDU_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      MDU_DIV: begin
        if (b == ZERO) begin
          w_res_hi = a;
          w_res_lo = ALL_ONES;
        end else if ((a == MOST_NEG) && (b == ALL_ONES)) begin
          w_res_hi = ZERO;
          w_res_lo = a;
        end else begin
          w_res_hi = w_r_s;
          w_res_lo = w_q_s;
        end
      end
      MDU_DIVU: begin
        if (b == ZERO) begin
          w_res_hi = a;
          w_res_lo = ALL_ONES;
        end else begin
          w_res_hi = w_r_u;
          w_res_lo = w_q_u;
        end
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {w_res_hi, w_res_lo} = w_acc_s;
      MDU_MADDU: {w_res_hi, w_res_lo} = w_acc_u;
`endif
      default: begin
        w_res_hi = ZERO;
        w_res_lo = ZERO;
      end
    endcase
  end

  // Issue captures the pending result; HI/LO change only on MT* or at the final busy edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi      <= ZERO;
      r_lo      <= ZERO;
      r_pend_hi <= ZERO;
      r_pend_lo <= ZERO;
    end else begin
      if (w_load) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
      end
      if (w_issue && w_cls.is_mt) begin
        if (op == MDU_MTHI) begin
          r_hi <= a;
        end else begin
          r_lo <= a;
        end
      end else if (w_done) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end
  end

  assign busy = w_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed, table-driven bench for mdu_unit (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  mdu_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [3:0] o, input logic [31:0] va,
                     input logic [31:0] vb, input int lat, input logic [31:0] eh,
                     input logic [31:0] el);
    vec_t v;
    v.name = name; v.op = o; v.a = va; v.b = vb; v.lat = lat; v.hi = eh; v.lo = el;
    vecs.push_back(v);
  endtask

  // Issue one op, check busy/hold for lat cycles, then the committed result.
  task automatic run_op(input vec_t v, input logic [31:0] phi, input logic [31:0] plo);
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    for (int k = 0; k < v.lat; k++) begin
      chk($sformatf("%s busy[%0d]", v.name, k), {63'd0, busy}, 64'd1);
      chk($sformatf("%s hold[%0d]", v.name, k), {hi, lo}, {phi, plo});
      @(negedge clk);
    end
    chk($sformatf("%s busy_end", v.name), {63'd0, busy}, 64'd0);
    chk($sformatf("%s result", v.name), {hi, lo}, {v.hi, v.lo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] phi, plo;
    vec_t dv;
    reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);

    // Reset mid-MULT aborts without commit.
    start = 1'b1; op = 4'd1; a = 32'hFFFF_FFFF; b = 32'd2;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    chk("abort busy_before", {63'd0, busy}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort busy_now", {63'd0, busy}, 64'd0);
    chk("abort hilo_now", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort busy_later", {63'd0, busy}, 64'd0);
    chk("abort hilo_later", {hi, lo}, 64'd0);

    add("mult_neg1x2",   4'd1, 32'hFFFF_FFFF, 32'd2,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    add("multu_ffx2",    4'd2, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE);
    add("div_m7_2",      4'd3, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add("divu_7_2",      4'd4, 32'd7,         32'd2,         10, 32'd1,         32'd3);
    add("div_5_0",       4'd3, 32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF);
    add("div_ovf",       4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000);
    add("divu_5_0",      4'd4, 32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF);
    add("mult_max",      4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5,  32'h3FFF_FFFF, 32'h0000_0001);
    add("mult_minmin",   4'd1, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000);
    add("div_7_m2",      4'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD);
    add("mthi",          4'd5, 32'h1234_5678, 32'd0,         0,  32'h1234_5678, 32'hFFFF_FFFD);
    add("mtlo",          4'd6, 32'h0000_ABCD, 32'd0,         0,  32'h1234_5678, 32'h0000_ABCD);
    add("op9_nop",       4'd9, 32'd1,         32'd1,         0,  32'h1234_5678, 32'h0000_ABCD);
    add("op0_nop",       4'd0, 32'd3,         32'd3,         0,  32'h1234_5678, 32'h0000_ABCD);
    add("mthi_zero",     4'd5, 32'd0,         32'd0,         0,  32'd0,         32'h0000_ABCD);
    add("mtlo_ones",     4'd6, 32'hFFFF_FFFF, 32'd0,         0,  32'd0,         32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    add("maddu_1_1",     4'd8, 32'd1,         32'd1,         5,  32'd1,         32'd0);
    add("madd_m1_1",     4'd7, 32'hFFFF_FFFF, 32'd1,         5,  32'd0,         32'hFFFF_FFFF);
`else
    add("maddu_off",     4'd8, 32'd1,         32'd1,         0,  32'd0,         32'hFFFF_FFFF);
    add("madd_off",      4'd7, 32'hFFFF_FFFF, 32'd1,         0,  32'd0,         32'hFFFF_FFFF);
`endif

    phi = 32'd0; plo = 32'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], phi, plo);
      phi = vecs[i].hi;
      plo = vecs[i].lo;
    end

    // MTHI issued while a DIV is in flight must be ignored.
    dv.name = "div_9_4"; dv.op = 4'd3; dv.a = 32'd9; dv.b = 32'd4; dv.lat = 10;
    dv.hi = 32'd1; dv.lo = 32'd2;
    @(negedge clk);
    start = 1'b1; op = dv.op; a = dv.a; b = dv.b;
    @(negedge clk);
    start = 1'b1; op = 4'd5; a = 32'h0000_1234; b = 32'd0;
    chk("busy_mthi busy0", {63'd0, busy}, 64'd1);
    @(negedge clk);
    start = 1'b0; op = 4'd0; a = 32'd0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("busy_mthi busy[%0d]", k), {63'd0, busy}, 64'd1);
      chk($sformatf("busy_mthi hold[%0d]", k), {hi, lo}, {phi, plo});
      @(negedge clk);
    end
    chk("busy_mthi busy_end", {63'd0, busy}, 64'd0);
    chk("busy_mthi result", {hi, lo}, {dv.hi, dv.lo});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
